// File: rtl/loop_predictor_table.sv
// Fully associative loop predictor table.
// Learns loop trip counts from EX-stage branch resolution and gives fetch a confident
// taken/not-taken override, including the not-taken on the exit iteration.
module loop_predictor_table #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned CNT_WIDTH   = 10,
  parameter int unsigned CONF_WIDTH  = 2,
  parameter int unsigned CONF_THRESH = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  lp_hit,
  output logic                  lp_valid,
  output logic                  lp_predict_taken,
  input  logic                  br_valid_ex,
  input  logic [ADDR_WIDTH-1:0] br_pc_ex,
  input  logic                  br_taken_ex,
  input  logic                  br_backward_ex,
  input  logic                  flush_all
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned TagW = ADDR_WIDTH - 1;

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TagW-1:0]       tag_q  [ENTRIES];
  logic [TagW-1:0]       tag_d  [ENTRIES];
  logic [CNT_WIDTH-1:0]  iter_q [ENTRIES];
  logic [CNT_WIDTH-1:0]  iter_d [ENTRIES];
  logic [CNT_WIDTH-1:0]  trip_q [ENTRIES];
  logic [CNT_WIDTH-1:0]  trip_d [ENTRIES];
  logic [CONF_WIDTH-1:0] conf_q [ENTRIES];
  logic [CONF_WIDTH-1:0] conf_d [ENTRIES];
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;

  logic            lk_hit;
  logic [IdxW-1:0] lk_idx;
  logic            up_hit;
  logic [IdxW-1:0] up_idx;
  logic            free_any;
  logic [IdxW-1:0] free_idx;
  logic [IdxW-1:0] alloc_idx;

  // Bit 0 of a pc is not part of the tag.
  logic unused_pc_lsb;
  assign unused_pc_lsb = pc[0] ^ br_pc_ex[0];

  // Fetch lookup and EX-side match/free search; descending scan makes the lowest index win.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    up_hit   = 1'b0;
    up_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == pc[ADDR_WIDTH-1:1])) begin
        lk_hit = 1'b1;
        lk_idx = IdxW'(i);
      end
      if (valid_q[i] && (tag_q[i] == br_pc_ex[ADDR_WIDTH-1:1])) begin
        up_hit = 1'b1;
        up_idx = IdxW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Prediction outputs from committed state only (no same-cycle bypass).
  always_comb begin
    lp_hit           = lk_hit;
    lp_valid         = lk_hit && (conf_q[lk_idx] >= CONF_WIDTH'(CONF_THRESH));
    lp_predict_taken = lk_hit && (iter_q[lk_idx] != trip_q[lk_idx]);
  end

  // Next-state: flush beats training; training on hit, allocation on backward taken miss.
  always_comb begin
    valid_d   = valid_q;
    rr_ptr_d  = rr_ptr_q;
    alloc_idx = free_any ? free_idx : rr_ptr_q;
    for (int i = 0; i < ENTRIES; i++) begin
      tag_d[i]  = tag_q[i];
      iter_d[i] = iter_q[i];
      trip_d[i] = trip_q[i];
      conf_d[i] = conf_q[i];
    end
    if (flush_all) begin
      valid_d  = '0;
      rr_ptr_d = '0;
    end else if (br_valid_ex) begin
      if (up_hit) begin
        if (br_taken_ex) begin
          // Counter would overflow: the loop is too long to track, drop it.
          if (iter_q[up_idx] == '1) begin
            valid_d[up_idx] = 1'b0;
          end else begin
            iter_d[up_idx] = iter_q[up_idx] + CNT_WIDTH'(1);
          end
        end else begin
          if (iter_q[up_idx] == trip_q[up_idx]) begin
            if (conf_q[up_idx] != '1) begin
              conf_d[up_idx] = conf_q[up_idx] + CONF_WIDTH'(1);
            end
          end else begin
            trip_d[up_idx] = iter_q[up_idx];
            conf_d[up_idx] = '0;
          end
          iter_d[up_idx] = '0;
        end
      end else if (br_taken_ex && br_backward_ex) begin
        if (!free_any) begin
          rr_ptr_d = rr_ptr_q + IdxW'(1);
        end
        valid_d[alloc_idx] = 1'b1;
        tag_d[alloc_idx]   = br_pc_ex[ADDR_WIDTH-1:1];
        iter_d[alloc_idx]  = CNT_WIDTH'(1);
        trip_d[alloc_idx]  = '0;
        conf_d[alloc_idx]  = '0;
      end
    end
  end

  // Table state with asynchronous clear.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        iter_q[i] <= '0;
        trip_q[i] <= '0;
        conf_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= tag_d[i];
        iter_q[i] <= iter_d[i];
        trip_q[i] <= trip_d[i];
        conf_q[i] <= conf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_loop_predictor_table.sv
// Directed bench for loop_predictor_table: training, exit prediction, replacement,
// flush priority, asynchronous reset and counter overflow (narrow-counter instance).
module tb_loop_predictor_table;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] pc;
  logic        br_valid_ex;
  logic [31:0] br_pc_ex;
  logic        br_taken_ex;
  logic        br_backward_ex;
  logic        flush_all;
  logic        lp_hit, lp_valid, lp_taken;
  logic        lp_hit4, lp_valid4, lp_taken4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 cpu_clk = ~cpu_clk;

  loop_predictor_table dut (
    .cpu_clk          (cpu_clk),
    .cpu_rst          (cpu_rst),
    .pc               (pc),
    .lp_hit           (lp_hit),
    .lp_valid         (lp_valid),
    .lp_predict_taken (lp_taken),
    .br_valid_ex      (br_valid_ex),
    .br_pc_ex         (br_pc_ex),
    .br_taken_ex      (br_taken_ex),
    .br_backward_ex   (br_backward_ex),
    .flush_all        (flush_all)
  );

  loop_predictor_table #(.CNT_WIDTH(4)) dut4 (
    .cpu_clk          (cpu_clk),
    .cpu_rst          (cpu_rst),
    .pc               (pc),
    .lp_hit           (lp_hit4),
    .lp_valid         (lp_valid4),
    .lp_predict_taken (lp_taken4),
    .br_valid_ex      (br_valid_ex),
    .br_pc_ex         (br_pc_ex),
    .br_taken_ex      (br_taken_ex),
    .br_backward_ex   (br_backward_ex),
    .flush_all        (flush_all)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One resolving branch, applied at the next rising edge.
  task automatic br(input logic [31:0] a, input logic tk, input logic bw);
    br_pc_ex       = a;
    br_taken_ex    = tk;
    br_backward_ex = bw;
    br_valid_ex    = 1'b1;
    @(posedge cpu_clk);
    #1;
    br_valid_ex = 1'b0;
  endtask

  // One loop instance: n taken iterations then the exit.
  task automatic run_loop(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) br(a, 1'b1, 1'b1);
    br(a, 1'b0, 1'b1);
  endtask

  task automatic look(input string tag, input logic [31:0] a,
                      input logic h, input logic v, input logic t);
    @(negedge cpu_clk);
    pc = a;
    #1;
    check_eq({tag, "_hit"}, 32'(lp_hit), 32'(h));
    check_eq({tag, "_valid"}, 32'(lp_valid), 32'(v));
    check_eq({tag, "_taken"}, 32'(lp_taken), 32'(t));
  endtask

  task automatic pulse_reset();
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  initial begin
    cpu_rst        = 1'b1;
    pc             = 32'h100;
    br_valid_ex    = 1'b0;
    br_pc_ex       = '0;
    br_taken_ex    = 1'b0;
    br_backward_ex = 1'b0;
    flush_all      = 1'b0;
    #2;
    check_eq("rst_hit", 32'(lp_hit), 32'd0);
    check_eq("rst_valid", 32'(lp_valid), 32'd0);
    check_eq("rst_taken", 32'(lp_taken), 32'd0);
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    look("post_rst", 32'h100, 1'b0, 1'b0, 1'b0);

    // Training: trip=4, confidence climbs 0 -> 1 -> 2.
    run_loop(32'h100, 4);
    look("inst1", 32'h100, 1'b1, 1'b0, 1'b1);
    run_loop(32'h100, 4);
    look("inst2", 32'h100, 1'b1, 1'b0, 1'b1);
    run_loop(32'h100, 4);
    look("inst3_it0", 32'h100, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) br(32'h100, 1'b1, 1'b1);
    look("inst4_it3", 32'h100, 1'b1, 1'b1, 1'b1);
    br(32'h100, 1'b1, 1'b1);
    look("inst4_it4_exit", 32'h100, 1'b1, 1'b1, 1'b0);
    br(32'h100, 1'b0, 1'b1);
    look("inst4_done", 32'h100, 1'b1, 1'b1, 1'b1);

    // Retrain with a longer trip: confidence drops to 0.
    run_loop(32'h100, 6);
    look("retrain6", 32'h100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) br(32'h100, 1'b1, 1'b1);
    look("trip6_it5", 32'h100, 1'b1, 1'b0, 1'b1);
    br(32'h100, 1'b1, 1'b1);
    look("trip6_it6", 32'h100, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    @(negedge cpu_clk);
    pc      = 32'h100;
    cpu_rst = 1'b1;
    #1;
    check_eq("async_rst_hit", 32'(lp_hit), 32'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    look("after_async_rst", 32'h100, 1'b0, 1'b0, 1'b0);

    // Forward taken miss and backward not-taken miss do not allocate.
    br(32'h400, 1'b1, 1'b0);
    look("fwd_miss", 32'h400, 1'b0, 1'b0, 1'b0);
    br(32'h404, 1'b0, 1'b1);
    look("nt_miss", 32'h404, 1'b0, 1'b0, 1'b0);

    // Fill all 8 entries, then round-robin replacement from entry 0.
    for (int i = 0; i < 8; i++) br(32'h200 + 32'(4 * i), 1'b1, 1'b1);
    look("fill_first", 32'h200, 1'b1, 1'b0, 1'b1);
    look("fill_last", 32'h21C, 1'b1, 1'b0, 1'b1);
    br(32'h300, 1'b1, 1'b1);
    look("repl0_old", 32'h200, 1'b0, 1'b0, 1'b0);
    look("repl0_new", 32'h300, 1'b1, 1'b0, 1'b1);
    look("repl0_keep", 32'h204, 1'b1, 1'b0, 1'b1);
    br(32'h304, 1'b1, 1'b1);
    look("repl1_old", 32'h204, 1'b0, 1'b0, 1'b0);
    look("repl1_keep", 32'h208, 1'b1, 1'b0, 1'b1);
    look("repl1_new", 32'h304, 1'b1, 1'b0, 1'b1);
    br(32'h100, 1'b1, 1'b1);
    look("repl2_old", 32'h208, 1'b0, 1'b0, 1'b0);
    look("repl2_new", 32'h100, 1'b1, 1'b0, 1'b1);

    // Flush wins over a same-cycle taken hit.
    br_pc_ex       = 32'h100;
    br_taken_ex    = 1'b1;
    br_backward_ex = 1'b1;
    br_valid_ex    = 1'b1;
    flush_all      = 1'b1;
    @(posedge cpu_clk);
    #1;
    br_valid_ex = 1'b0;
    flush_all   = 1'b0;
    look("flush_100", 32'h100, 1'b0, 1'b0, 1'b0);
    look("flush_300", 32'h300, 1'b0, 1'b0, 1'b0);
    look("flush_21c", 32'h21C, 1'b0, 1'b0, 1'b0);
    // Replacement pointer was cleared: after refill the victim is entry 0.
    for (int i = 0; i < 8; i++) br(32'h500 + 32'(4 * i), 1'b1, 1'b1);
    br(32'h600, 1'b1, 1'b1);
    look("rr_cleared_old0", 32'h500, 1'b0, 1'b0, 1'b0);
    look("rr_cleared_keep3", 32'h50C, 1'b1, 1'b0, 1'b1);
    look("rr_cleared_new", 32'h600, 1'b1, 1'b0, 1'b1);

    // Overflow on the 4-bit counter instance: 15 taken fits, the 16th drops the entry.
    pulse_reset();
    for (int i = 0; i < 15; i++) br(32'h100, 1'b1, 1'b1);
    @(negedge cpu_clk);
    pc = 32'h100;
    #1;
    check_eq("ovf_pre_hit4", 32'(lp_hit4), 32'd1);
    check_eq("ovf_pre_taken4", 32'(lp_taken4), 32'd1);
    br(32'h100, 1'b1, 1'b1);
    @(negedge cpu_clk);
    #1;
    check_eq("ovf_post_hit4", 32'(lp_hit4), 32'd0);
    check_eq("ovf_post_taken4", 32'(lp_taken4), 32'd0);
    check_eq("ovf_wide_hit", 32'(lp_hit), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
